// File: rtl/vga_csr_arbiter.sv
// vga_csr_arbiter: shares the video-memory CSR port, display first; display latency LAT, CPU read >= LAT+2.
// Display is never stalled; CPU waits for a free slot. VGA_CSR_WBUF_EN adds a posted-write FIFO (WBUF_DEPTH).
module vga_csr_arbiter #(
   parameter int unsigned LAT        = 2,
   parameter int unsigned WBUF_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [16:0] lcd_adr_i,
   input  logic        lcd_stb_i,
   output logic [15:0] lcd_dat_o,
   input  logic [16:0] cpu_adr_i,
   input  logic        cpu_we_i,
   input  logic [1:0]  cpu_sel_i,
   input  logic [15:0] cpu_dat_i,
   input  logic        cpu_stb_i,
   output logic [15:0] cpu_dat_o,
   output logic        cpu_ack_o,
   output logic [16:0] mem_adr_o,
   output logic        mem_we_o,
   output logic [1:0]  mem_sel_o,
   output logic [15:0] mem_dat_o,
   output logic        mem_stb_o,
   input  logic [15:0] mem_dat_i
);

   typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAIT, S_ACK} state_t;

   state_t         r_state;
   logic [16:0]    r_adr;
   logic           r_we;
   logic [15:0]    r_cpu_dat;
   logic           r_cpu_ack;
   logic [LAT-1:0] r_tag;

   logic w_cpu_slot;
   logic w_rd_issue;
   logic w_wr_issue;
   logic w_tag_exit;

   if (LAT < 1 || LAT > 4) begin : g_lat_chk
      $error("vga_csr_arbiter: LAT must be within 1..4");
   end
   if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("vga_csr_arbiter: WBUF_DEPTH must be a power of two >= 2");
   end

   assign lcd_dat_o  = mem_dat_i;
   assign cpu_dat_o  = r_cpu_dat;
   assign cpu_ack_o  = r_cpu_ack;
   assign w_rd_issue = w_cpu_slot && !r_we;
   assign w_wr_issue = w_cpu_slot && r_we;
   assign w_tag_exit = r_tag[LAT-1];

`ifdef VGA_CSR_WBUF_EN
   localparam int unsigned AW = $clog2(WBUF_DEPTH);

   typedef struct packed {
      logic [16:0] adr;
      logic [1:0]  sel;
      logic [15:0] dat;
   } wbuf_ent_t;

   wbuf_ent_t r_wbuf [WBUF_DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   wbuf_ent_t   w_head;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_can_push;
   logic        w_push;

   // Extra pointer MSB distinguishes full from empty without a separate count.
   assign w_empty    = (r_wptr == r_rptr);
   assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_head     = r_wbuf[r_rptr[AW-1:0]];
   assign w_pop      = !lcd_stb_i && !w_empty;
   assign w_can_push = !w_full || w_pop;
   assign w_push     = (r_state == S_IDLE) && cpu_stb_i && cpu_we_i && w_can_push;
   // Reads wait for an empty FIFO so they always see earlier posted writes.
   assign w_cpu_slot = !lcd_stb_i && w_empty && (r_state == S_PEND);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_wbuf[r_wptr[AW-1:0]] <= '{adr: cpu_adr_i, sel: cpu_sel_i, dat: cpu_dat_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         end
         if (w_pop) begin
            r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   always_comb begin
      mem_adr_o = '0;
      mem_we_o  = 1'b0;
      mem_sel_o = 2'b00;
      mem_dat_o = '0;
      mem_stb_o = 1'b0;
      if (lcd_stb_i) begin
         mem_adr_o = lcd_adr_i;
         mem_sel_o = 2'b11;
         mem_stb_o = 1'b1;
      end else if (!w_empty) begin
         mem_adr_o = w_head.adr;
         mem_we_o  = 1'b1;
         mem_sel_o = w_head.sel;
         mem_dat_o = w_head.dat;
         mem_stb_o = 1'b1;
      end else if (w_cpu_slot) begin
         mem_adr_o = r_adr;
         mem_sel_o = 2'b11;
         mem_stb_o = 1'b1;
      end
   end
`else
   logic [1:0]  r_sel;
   logic [15:0] r_dat;

   assign w_cpu_slot = !lcd_stb_i && (r_state == S_PEND);

   always_comb begin
      mem_adr_o = '0;
      mem_we_o  = 1'b0;
      mem_sel_o = 2'b00;
      mem_dat_o = '0;
      mem_stb_o = 1'b0;
      if (lcd_stb_i) begin
         mem_adr_o = lcd_adr_i;
         mem_sel_o = 2'b11;
         mem_stb_o = 1'b1;
      end else if (w_cpu_slot) begin
         mem_adr_o = r_adr;
         mem_we_o  = r_we;
         mem_sel_o = r_we ? r_sel : 2'b11;
         mem_dat_o = r_we ? r_dat : 16'h0000;
         mem_stb_o = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sel <= 2'b00;
         r_dat <= '0;
      end else if (r_state == S_IDLE && cpu_stb_i) begin
         r_sel <= cpu_sel_i;
         r_dat <= cpu_dat_i;
      end
   end
`endif

   // One tag per issued CPU read; it emerges exactly when that read's data is on mem_dat_i.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag <= '0;
      end else begin
         r_tag <= (r_tag << 1) | LAT'(w_rd_issue);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cpu_ack <= 1'b0;
         r_cpu_dat <= '0;
         r_adr     <= '0;
         r_we      <= 1'b0;
      end else begin
         r_cpu_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cpu_stb_i) begin
`ifdef VGA_CSR_WBUF_EN
                  if (cpu_we_i) begin
                     if (w_can_push) begin
                        r_state   <= S_ACK;
                        r_cpu_ack <= 1'b1;
                     end
                  end else begin
                     r_adr   <= cpu_adr_i;
                     r_we    <= 1'b0;
                     r_state <= S_PEND;
                  end
`else
                  r_adr   <= cpu_adr_i;
                  r_we    <= cpu_we_i;
                  r_state <= S_PEND;
`endif
               end
            end
            S_PEND: begin
               if (w_wr_issue) begin
                  r_state   <= S_ACK;
                  r_cpu_ack <= 1'b1;
               end else if (w_rd_issue) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (w_tag_exit) begin
                  r_cpu_dat <= mem_dat_i;
                  r_cpu_ack <= 1'b1;
                  r_state   <= S_ACK;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_csr_arbiter.sv
// Scoreboard bench for vga_csr_arbiter: driver pushes expected CPU responses, monitor pops on ack.
// A word-array memory model answers the memory port; display reads target a region the CPU never writes.
`timescale 1ns/1ps
module tb_vga_csr_arbiter;
   localparam int LAT        = 2;
   localparam int WBUF_DEPTH = 4;
`ifdef VGA_CSR_WBUF_EN
   localparam int WR_LAT = 1;
`else
   localparam int WR_LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] lcd_adr_i;
   logic        lcd_stb_i;
   logic [15:0] lcd_dat_o;
   logic [16:0] cpu_adr_i;
   logic        cpu_we_i;
   logic [1:0]  cpu_sel_i;
   logic [15:0] cpu_dat_i;
   logic        cpu_stb_i;
   logic [15:0] cpu_dat_o;
   logic        cpu_ack_o;
   logic [16:0] mem_adr_o;
   logic        mem_we_o;
   logic [1:0]  mem_sel_o;
   logic [15:0] mem_dat_o;
   logic        mem_stb_o;
   logic [15:0] mem_dat_i;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vga_csr_arbiter #(.LAT(LAT), .WBUF_DEPTH(WBUF_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .lcd_adr_i(lcd_adr_i), .lcd_stb_i(lcd_stb_i), .lcd_dat_o(lcd_dat_o),
      .cpu_adr_i(cpu_adr_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
      .cpu_dat_i(cpu_dat_i), .cpu_stb_i(cpu_stb_i), .cpu_dat_o(cpu_dat_o),
      .cpu_ack_o(cpu_ack_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
      .mem_sel_o(mem_sel_o), .mem_dat_o(mem_dat_o), .mem_stb_o(mem_stb_o),
      .mem_dat_i(mem_dat_i)
   );

   function automatic logic [15:0] pat(input logic [16:0] a);
      return a[15:0] ^ 16'hA55A;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   // Memory slave: data for a read strobed in cycle c appears on mem_dat_i in cycle c+LAT.
   logic [15:0] sim_mem [131072];
   logic [15:0] ref_mem [131072];
   logic [15:0] rd_pipe [LAT];
   assign mem_dat_i = rd_pipe[LAT-1];

   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= (mem_stb_o && !mem_we_o) ? sim_mem[mem_adr_o] : 16'h0000;
      if (mem_stb_o && mem_we_o) begin
         if (mem_sel_o[0]) sim_mem[mem_adr_o][7:0]  = mem_dat_o[7:0];
         if (mem_sel_o[1]) sim_mem[mem_adr_o][15:8] = mem_dat_o[15:8];
      end
   end

   typedef struct {
      logic        is_rd;
      logic [15:0] dat;
   } exp_t;
   exp_t sb_q[$];

   logic        lcd_vld [8];
   logic [15:0] lcd_exp [8];
   int          wr_seen = 0;
   int          wr_acked = 0;
   int          last_rd_cyc = -1;
   logic [1:0]  last_wr_sel = 2'b00;

   always @(negedge clk) begin : mon
      exp_t e;
      int   pi;
      pi = (cyc - LAT) & 7;
      if (cyc >= LAT && lcd_vld[pi]) begin
         chk("lcd_dat", lcd_dat_o, lcd_exp[pi]);
         lcd_vld[pi] = 1'b0;
      end
      if (lcd_stb_i) begin
         chk("disp_mux", {mem_stb_o, mem_we_o, mem_sel_o, mem_adr_o}, {1'b1, 1'b0, 2'b11, lcd_adr_i});
         lcd_vld[cyc & 7] = 1'b1;
         lcd_exp[cyc & 7] = pat(lcd_adr_i);
      end else if (mem_stb_o && mem_we_o) begin
         wr_seen++;
         last_wr_sel = mem_sel_o;
      end else if (mem_stb_o) begin
         chk("rd_after_wr", wr_seen, wr_acked);
         last_rd_cyc = cyc;
      end else begin
         chk("idle_zero", {mem_adr_o, mem_we_o, mem_sel_o, mem_dat_o}, 36'h0);
      end
      if (cpu_ack_o) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack actual=ack required=no_ack cyc=%0d", cyc);
         end else begin
            e = sb_q.pop_front();
            if (e.is_rd) chk("cpu_rd_dat", cpu_dat_o, e.dat);
            else wr_acked++;
         end
      end
   end

   int lcd_mode = 0;
   initial begin
      lcd_stb_i = 1'b0;
      lcd_adr_i = '0;
      forever begin
         @(posedge clk);
         #2;
         lcd_adr_i = {1'b1, 16'($urandom)};
         case (lcd_mode)
            1:       lcd_stb_i = 1'b1;
            2:       lcd_stb_i = ($urandom_range(0, 2) == 0);
            default: lcd_stb_i = 1'b0;
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ref_wr(input logic [16:0] adr, input logic [1:0] sel, input logic [15:0] dat);
      if (sel[0]) ref_mem[adr][7:0]  = dat[7:0];
      if (sel[1]) ref_mem[adr][15:8] = dat[15:8];
   endtask

   task automatic cpu_xact(input logic we, input logic [16:0] adr, input logic [1:0] sel,
                           input logic [15:0] dat, output int t0, output int t_ack);
      exp_t e;
      bit   got;
      got = 1'b0;
      cpu_we_i  = we;
      cpu_adr_i = adr;
      cpu_sel_i = sel;
      cpu_dat_i = dat;
      cpu_stb_i = 1'b1;
      t0    = cyc;
      t_ack = -1;
      if (we) begin
         ref_wr(adr, sel, dat);
         e.is_rd = 1'b0;
         e.dat   = 16'h0000;
      end else begin
         e.is_rd = 1'b1;
         e.dat   = ref_mem[adr];
      end
      sb_q.push_back(e);
      for (int k = 0; k < 500 && !got; k++) begin
         @(negedge clk);
         if (cpu_ack_o) begin
            got   = 1'b1;
            t_ack = cyc;
         end
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL ack_timeout actual=no_ack required=ack adr=%0h", adr);
      end
      @(posedge clk);
      #1;
      cpu_stb_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          t0, ta, s, ldrop;
      int          ack_at [5];
      logic [15:0] d;
      rst = 1'b1;
      cpu_adr_i = '0; cpu_we_i = 1'b0; cpu_sel_i = 2'b00; cpu_dat_i = '0; cpu_stb_i = 1'b0;
      for (int a = 0; a < 131072; a++) begin
         sim_mem[a] = pat(17'(a));
         ref_mem[a] = pat(17'(a));
      end
      for (int i = 0; i < 8; i++) lcd_vld[i] = 1'b0;
      idle(3);
      @(negedge clk);
      chk("reset_ack", cpu_ack_o, 1'b0);
      chk("reset_dat", cpu_dat_o, 16'h0000);
      chk("reset_mem_stb", mem_stb_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle(2);

      cpu_xact(1'b1, 17'h00100, 2'b11, 16'hBEEF, t0, ta);
      chk("wr_ack_lat", ta - t0, WR_LAT);
      idle(4);
      cpu_xact(1'b0, 17'h00100, 2'b00, 16'h0000, t0, ta);
      chk("rd_issue_cyc", last_rd_cyc, t0 + 1);
      chk("rd_ack_lat", ta - t0, LAT + 2);
      chk("rd_beef", cpu_dat_o, 16'hBEEF);

      idle(2);
      lcd_mode = 1;
      fork
         cpu_xact(1'b0, 17'h00005, 2'b11, 16'h0000, t0, ta);
         begin
            idle(100);
            lcd_mode = 0;
            ldrop = cyc;
         end
      join
      chk("prio_rd_issue", last_rd_cyc, ldrop);
      chk("prio_ack", ta, ldrop + LAT + 1);

`ifdef VGA_CSR_WBUF_EN
      idle(2);
      s = cyc;
      lcd_mode = 1;
      fork
         for (int i = 0; i < 5; i++) begin
            cpu_xact(1'b1, 17'h00030, 2'b11, 16'h1000 + 16'(i), t0, ta);
            ack_at[i] = ta;
         end
         begin
            idle(20);
            lcd_mode = 0;
            ldrop = cyc;
         end
      join
      for (int i = 0; i < 4; i++) chk("post_ack", ack_at[i], s + 1 + 2 * i);
      chk("post_full_ack", ack_at[4], ldrop + 1);
      cpu_xact(1'b0, 17'h00030, 2'b00, 16'h0000, t0, ta);
`endif

      lcd_mode = 2;
      for (int i = 0; i < 3; i++) begin
         d = 16'($urandom);
         cpu_xact(1'b1, 17'h00010, 2'b11, d, t0, ta);
      end
      cpu_xact(1'b0, 17'h00010, 2'b00, 16'h0000, t0, ta);
      chk("raw_data", cpu_dat_o, d);

      lcd_mode = 0;
      idle(2);
      cpu_xact(1'b1, 17'h00020, 2'b11, 16'hFFFF, t0, ta);
      cpu_xact(1'b1, 17'h00020, 2'b01, 16'h12AB, t0, ta);
      idle(3);
      chk("bytesel_sel", last_wr_sel, 2'b01);
      cpu_xact(1'b0, 17'h00020, 2'b00, 16'h0000, t0, ta);
      chk("bytesel_rd", cpu_dat_o, 16'hFFAB);

      idle(2);
      cpu_we_i  = 1'b0;
      cpu_adr_i = 17'h00100;
      cpu_stb_i = 1'b1;
      idle(2);
      rst       = 1'b1;
      cpu_stb_i = 1'b0;
      idle(1);
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_ack", cpu_ack_o, 1'b0);
      chk("rstmid_dat", cpu_dat_o, 16'h0000);
      chk("rstmid_mem_stb", mem_stb_o, 1'b0);
      @(posedge clk); #1;
      idle(6);
      cpu_xact(1'b0, 17'h00020, 2'b00, 16'h0000, t0, ta);
      chk("rstmid_next_lat", ta - t0, LAT + 2);

      lcd_mode = 2;
      for (int i = 0; i < 150; i++) begin
         cpu_xact(1'($urandom), 17'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  16'($urandom), t0, ta);
         idle($urandom_range(0, 2));
      end

      lcd_mode = 0;
      idle(20);
      for (int a = 0; a < 64; a++) chk("mem_final", sim_mem[a], ref_mem[a]);
      chk("mem_final_100", sim_mem[17'h00100], ref_mem[17'h00100]);
      chk("sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
